// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and helpers for the multiplexed BCD display scanner
package seg_scan_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int IDX_W = 2;
    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] BCD_MAX = 4'd9;
    function automatic logic has_bad(input logic [15:0] v);
        has_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[4*i +: 4] > BCD_MAX) has_bad = 1'b1;
    endfunction
endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: value-load handshake and decoder/anode pins between the counter logic and the scanner
interface seg_scan_if;
    logic        enable;
    logic        blank_lz;
    logic        load;
    logic [15:0] load_value;
    logic        load_ack;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        bcd_err;
    modport master (output enable, blank_lz, load, load_value, input load_ack, bcd, an, bcd_err);
    modport slave  (input enable, blank_lz, load, load_value, output load_ack, bcd, an, bcd_err);
endinterface

// File: rtl/seg_scan_tick.sv
// seg_scan_tick: slot prescaler; counts 0..REFRESH_DIV-1 while enabled and flags the last cycle of a slot
module seg_scan_tick #(
    parameter int REFRESH_DIV = 100000,
    localparam int TW = $clog2(REFRESH_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic [TW-1:0] tick,
    output logic          slot_end
);
    assign slot_end = enable && tick == TW'(REFRESH_DIV - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tick <= '0;
        else tick <= (!enable || slot_end) ? '0 : tick + 1'b1;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scans a double-buffered 4-digit BCD value onto one shared decoder and active-low anodes,
// with per-slot dead time and optional leading-zero blanking
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_TICKS  = 1000
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);
    localparam int TW = $clog2(REFRESH_DIV);
    logic [TW-1:0]    tick;
    logic             slot_end, frame_end, commit, pending, blanked;
    logic [IDX_W-1:0] idx;
    logic [15:0]      pbuf, active;
    logic [3:0]       nib;
    seg_scan_tick #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (bus.enable),
        .tick     (tick),
        .slot_end (slot_end)
    );
    // Commits only at a frame boundary, or immediately while dark since nothing can tear
    always_comb begin
        frame_end = slot_end && idx == IDX_W'(NUM_DIGITS - 1);
        commit    = pending && (frame_end || !bus.enable);
        nib       = active[{idx, 2'b00} +: 4];
        blanked   = nib > BCD_MAX || (bus.blank_lz && idx != '0 && (active >> {idx, 2'b00}) == 16'd0);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx     <= '0;
            pending <= 1'b0;
            pbuf    <= '0;
            active  <= '0;
        end else begin
            idx     <= !bus.enable ? '0 : slot_end ? idx + 1'b1 : idx;
            pending <= bus.load || (pending && !commit);
            if (bus.load) pbuf <= bus.load_value;
            if (commit) active <= pbuf;
        end
    // Output stage is one cycle behind the counters
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.load_ack <= 1'b0;
            bus.bcd_err  <= 1'b0;
            bus.bcd      <= '0;
            bus.an       <= AN_OFF;
        end else begin
            bus.load_ack <= commit;
            if (commit) bus.bcd_err <= has_bad(pbuf);
            bus.bcd <= nib;
            bus.an  <= (bus.enable && tick >= TW'(DEAD_TICKS) && !blanked) ? ~(4'b0001 << idx) : AN_OFF;
        end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench; a cycle-count reference model predicts every output cycle,
// a negedge monitor pops and compares
module tb_seg_scan_ctrl;
    localparam int RD = 4;
    localparam int DT = 1;

    typedef struct {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       ack;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0, bad = 0, acks = 0, other_lit = 0;
    exp_t q[$];

    int          en_cyc = 0;
    logic [15:0] m_act = '0, m_pbuf = '0;
    logic        m_pend = 1'b0, m_err = 1'b0;

    always #5 clk = ~clk;

    seg_scan_if bus ();
    seg_scan_ctrl #(.REFRESH_DIV(RD), .DEAD_TICKS(DT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic nib_bad(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: slot position and digit come straight from the count of enabled cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cyc = 0;
            m_act  = '0;
            m_pbuf = '0;
            m_pend = 1'b0;
            m_err  = 1'b0;
            q.delete();
        end else begin
            exp_t e;
            int tk, ix, d;
            logic cm, dark;
            tk   = en_cyc % RD;
            ix   = (en_cyc / RD) % 4;
            cm   = m_pend && (!bus.enable || en_cyc % (4 * RD) == 4 * RD - 1);
            d    = int'((m_act >> (4 * ix)) & 16'hF);
            dark = !bus.enable || tk < DT || d > 9 || (bus.blank_lz && ix > 0 && (m_act >> (4 * ix)) == 16'd0);
            e.an  = dark ? 4'hF : 4'hF ^ (4'h1 << ix);
            e.bcd = 4'(d);
            e.ack = cm;
            e.err = cm ? nib_bad(m_pbuf) : m_err;
            q.push_back(e);
            if (cm) begin
                m_act = m_pbuf;
                m_err = e.err;
            end
            if (bus.load) begin
                m_pbuf = bus.load_value;
                m_pend = 1'b1;
            end else if (cm) m_pend = 1'b0;
            en_cyc = bus.enable ? en_cyc + 1 : 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_an", 16'(bus.an), 16'hF);
            chk("rst_bcd", 16'(bus.bcd), 16'h0);
            chk("rst_ack", 16'(bus.load_ack), 16'h0);
        end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("an", 16'(bus.an), 16'(e.an));
            chk("bcd", 16'(bus.bcd), 16'(e.bcd));
            chk("load_ack", 16'(bus.load_ack), 16'(e.ack));
            chk("bcd_err", 16'(bus.bcd_err), 16'(e.err));
            chk("an_onehot", 16'($countones(~bus.an) <= 1), 16'h1);
            if (bus.load_ack) acks++;
            if (bus.an != 4'hF && bus.an != 4'hE) other_lit++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load = 1'b1;
        bus.load_value = v;
        cyc(1);
        bus.load = 1'b0;
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        int r;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 19);
            v[4*i +: 4] = r < 6 ? 4'd0 : r < 18 ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    initial begin
        int a0;
        bus.enable = 1'b0;
        bus.blank_lz = 1'b0;
        bus.load = 1'b0;
        bus.load_value = '0;
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        cyc(1);
        bus.enable = 1'b1;
        cyc(18);
        a0 = acks;
        do_load(16'h1234);
        cyc(24);
        chk("ack_1234", 16'(acks - a0), 16'd1);
        bus.blank_lz = 1'b1;
        a0 = acks;
        do_load(16'h0011);
        cyc(2);
        do_load(16'h0099);
        cyc(24);
        chk("ack_latest_wins", 16'(acks - a0), 16'd1);
        do_load(16'h00A5);
        cyc(24);
        chk("err_set", 16'(bus.bcd_err), 16'h1);
        do_load(16'h0005);
        cyc(24);
        chk("err_clr", 16'(bus.bcd_err), 16'h0);
        do_load(16'h0000);
        cyc(20);
        other_lit = 0;
        cyc(32);
        chk("zero_only_d0", 16'(other_lit), 16'd0);
        a0 = acks;
        do_load(16'h0777);
        bus.enable = 1'b0;
        cyc(3);
        chk("ack_on_disable", 16'(acks - a0), 16'd1);
        chk("dark_an", 16'(bus.an), 16'hF);
        bus.enable = 1'b1;
        cyc(2);
        a0 = acks;
        do_load(16'h0123);
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 16'(bus.an), 16'hF);
        chk("async_bcd", 16'(bus.bcd), 16'h0);
        cyc(2);
        #3 rst_n = 1'b1;
        cyc(40);
        chk("no_ack_after_rst", 16'(acks - a0), 16'd0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.load = 1'b1;
                bus.load_value = rand_val();
            end else bus.load = 1'b0;
            if ($urandom_range(0, 59) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 49) == 0) bus.blank_lz = ~bus.blank_lz;
            cyc(1);
        end
        bus.load = 1'b0;
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexes a 4-digit BCD value onto the board's single shared BCD-to-seven-segment decoder and the four active-low digit anodes. It owns refresh timing, per-slot dead-time, leading-zero blanking and tear-free value updates through a double buffer with a load/ack handshake. It sits between the parking-counter logic, which supplies the values, and the decoder/anode pins at top level.

Parameters:
NUM_DIGITS, 4, digits scanned; the index counter is 2 bits wide, and only 4 is supported.
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); must be at least 2.
DEAD_TICKS, 1000, cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.

Ports:
clk  in  1  system clock; the only clock.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  1 = scanning; 0 = display dark and counters cleared.
blank_lz  in  1  1 = suppress leading zeros.
load  in  1  request to display load_value; sampled every cycle.
load_value  in  16  four BCD digits, [15:12] MSD through [3:0] LSD.
load_ack  out  1  one-cycle pulse when a loaded value becomes the displayed value.
bcd  out  4  digit code sent to the shared decoder.
an  out  4  anodes, active-low; an[i] drives digit i, with digit 0 as the LSD.
bcd_err  out  1  sticky; set when the committed value contains a nibble greater than 9.

Behaviour:
- Reset (async, rst_n=0): an=4'b1111, bcd=0, load_ack=0, bcd_err=0. Tick counter, digit index, pending flag, pending buffer and active buffer all clear to 0.
- Tick counter runs 0..REFRESH_DIV-1 while enable=1. At terminal count it wraps to 0 and the digit index advances idx -> idx+1 mod 4.
- Frame boundary: the cycle where the index wraps from 3 to 0.
- Load handshake:
  - load=1 writes load_value into the pending buffer and sets pending.
  - If pending is already 1, the new value overwrites the buffer (latest wins). No ack is issued for the overwritten value.
  - At the frame boundary, if pending=1: active <= pending buffer, pending cleared.
  - load_ack pulses for exactly the one cycle after the commit.
  - load=1 in the same cycle as a commit: the committed value is the one held before that cycle, and the new value becomes pending. Pending therefore stays 1, and the ack still pulses.
- bcd_err: updated at each commit to (any nibble of the new active value > 9). Held between commits.
- Output stage, registered (one cycle behind the counters):
  - bcd = active nibble[idx].
  - an[idx] = 0 only when all of the following hold: enable=1, tick >= DEAD_TICKS, digit not blanked, nibble <= 9. Otherwise an=4'b1111.
  - Exactly one anode may be low in any cycle.
- Blanking:
  - Invalid nibbles (>9) are always blanked.
  - With blank_lz=1, digit i (i=3,2,1) is blanked when nibbles 3..i are all zero. Digit 0 is never blanked by zero suppression, so 0000 shows "0".
- enable=0:
  - Tick and idx are held at 0; an=4'b1111 on the next cycle.
  - A pending value commits on the first cycle with enable=0, since no frame can tear.
- enable rising: the scan restarts at idx=0, tick=0, and the first anode goes low at tick DEAD_TICKS, plus one cycle of output latency.
- Reset mid-frame: everything returns to reset values immediately (async). A pending value is discarded with no ack.

Decomposition:
- Shared display package holds: NUM_DIGITS, the anode-off constant 4'b1111, the BCD max value 9, and the idx width.
- One natural sub-module: seg_scan_tick, a prescaler that emits a slot_end pulse and exposes the tick count for dead-time compare.
- The decoder is not instantiated here. Top level connects bcd to the existing decoder, so the block stays decoder-agnostic.

Test Plan:
Bench parameters for all scenarios: REFRESH_DIV=4, DEAD_TICKS=1.
1. Reset then enable=1 with active=0 and blank_lz=0: an cycles 1110, 1101, 1011, 0111, with each anode low for 3 of every 4 cycles, all-high dead cycle first; bcd=0 throughout.
2. load=1 with 16'h1234 mid-frame: display unchanged until the frame boundary; load_ack pulses once the cycle after the commit; then bcd follows 4, 3, 2, 1 on an[0..3].
3. Two loads in one frame, 16'h0011 then 16'h0099: only 0099 is displayed and one ack is seen. With blank_lz=1, an[3] and an[2] stay high and digits 0 and 1 scan.
4. load 16'h00A5: bcd_err=1 after the commit, digit 1 is dark, digit 0 shows 5. Loading 16'h0005 clears bcd_err.
5. load 16'h0000 with blank_lz=1: only an[0] ever goes low, with bcd=0.
6. enable=0 with a value pending: commit and ack occur on the next cycle and an=1111. Also, asserting rst_n=0 mid-slot forces an=1111 and bcd=0 asynchronously, and no ack is issued.
